bin2x2_filter: RTL and testbench
================================

BIN2X2_FILTER -- requirements
Module: bin2x2_filter

Interface
REQ-001 SHALL have parameter PIXEL_BIT_WIDTH, default 12, bits per pixel on input and output.
REQ-002 SHALL have parameter IN_ROWS, default 20, rows per input frame; must be even and >= 2.
REQ-003 SHALL have parameter IN_COLS, default 20, columns per input frame; must be even and >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pixel_in  input  PIXEL_BIT_WIDTH  cropped pixel, row-major raster order from the upstream crop stage.
REQ-007 SHALL have port in_valid  input  1  pixel_in valid.
REQ-008 SHALL have port in_ready  output  1  block can accept pixel_in this cycle.
REQ-009 SHALL have port pixel_out  output  PIXEL_BIT_WIDTH  binned pixel.
REQ-010 SHALL have port out_valid  output  1  pixel_out valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts pixel_out.
REQ-012 SHALL have port out_eof  output  1  high with the last binned pixel of a frame; qualified by out_valid.

Function
REQ-013 SHALL accept an input beat only when in_valid and in_ready are both high; the beat advances column counter x (0..IN_COLS-1) and row counter y (0..IN_ROWS-1).
REQ-014 SHALL wrap x to 0 after IN_COLS-1 and increment y; after x=IN_COLS-1, y=IN_ROWS-1 both SHALL wrap to 0 (next frame starts with no gap cycle).
REQ-015 SHALL hold the even-x pixel in a register and form horizontal sum h = p(even x) + p(x+1) on the odd-x beat, width PIXEL_BIT_WIDTH+1.
REQ-016 SHALL, on even rows, write h into line buffer entry x/2 (IN_COLS/2 entries, PIXEL_BIT_WIDTH+1 bits each) and produce no output.
REQ-017 SHALL, on odd rows at odd x, compute s = linebuf[x/2] + h (PIXEL_BIT_WIDTH+2 bits) and load pixel_out = s >> 2 (floor, no rounding) into the output register.
REQ-018 SHALL assert out_valid the cycle after the accepting beat of REQ-017 (latency 1 cycle) and hold pixel_out, out_eof stable until out_valid && out_ready.
REQ-019 SHALL drive in_ready = !out_valid || out_ready (combinational); an output register that is full and not drained stalls input.
REQ-020 SHALL, when an output is consumed and a new output is loaded in the same cycle, keep out_valid high with the new value (no bubble).
REQ-021 SHALL assert out_eof for the output produced at x=IN_COLS-1, y=IN_ROWS-1 only.
REQ-022 SHALL ignore pixel_in while in_valid is low; counters, line buffer and held pixel SHALL not change.
REQ-023 SHALL produce exactly (IN_ROWS/2)*(IN_COLS/2) outputs per input frame.

Reset
REQ-024 SHALL on reset clear x, y, held pixel and output register: out_valid=0, out_eof=0, pixel_out=0; in_ready=1 after reset.
REQ-025 SHALL, on reset asserted mid-frame, discard partial sums; the first beat after release is treated as x=0, y=0.
REQ-026 Line buffer contents need not be reset (always written on an even row before read).

Structure
REQ-027 SHALL place the valid/ready beat-fire helper widths and a shared pixel-width constant in the team's image-pipeline package alongside other stream constants.
REQ-028 SHALL implement the line buffer as sub-module bin_line_buffer (single write port, single combinational read port, depth IN_COLS/2).

Verification
REQ-029 4x4 frame, pixels 0..15 row-major, out_ready=1 -> outputs 2, 4, 10, 12; out_eof only on 12.
REQ-030 4x4 frame all 4095 -> four outputs of 4095, no overflow.
REQ-031 2x2 block 1,1,1,0 -> output 0 (floor of 3/4).
REQ-032 out_ready=0 for 5 cycles with output pending -> pixel_out held, in_ready=0, no input consumed; release -> stream resumes with no loss.
REQ-033 Reset asserted after 6 beats of a 4x4 frame, then full frame 0..15 -> outputs 2, 4, 10, 12 exactly.
REQ-034 Default 20x20, two back-to-back frames with random in_valid gaps -> 100 outputs per frame, each equal to floor of 2x2 block mean.

Source files
------------

// File: rtl/bin2x2_filter_pkg.sv
// Image-pipeline stream package shared by the binning stage.
// Contents:
//   PIX_W      - shared pixel width used by the pipeline stages
//   beat_fire  - valid/ready handshake helper (one beat moves when both are high)
//   cnt_w      - width of a counter or index that spans n values (never below 1)
package bin2x2_filter_pkg;

  localparam int PIX_W = 12;

  function automatic logic beat_fire(input logic valid, input logic ready);
    return valid & ready;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bin2x2_filter_line_buffer.sv
// Line buffer that holds the horizontal pair sums of the last even row.
// Ports:
//   clk        - clock, writes on rising edge
//   wr_en_i    - write strobe
//   wr_addr_i  - write index (pair number within the row)
//   wr_data_i  - pair sum to store
//   rd_addr_i  - read index
//   rd_data_o  - combinational read data
// Contents are never reset: every entry is written on an even row before the
// following odd row reads it.
module bin_line_buffer #(
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/bin2x2_filter.sv
// 2x2 binning filter: averages each non-overlapping 2x2 pixel block of a
// row-major raster frame into one output pixel (floor of the mean).
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - asynchronous active-high reset
//   pixel_in   - input pixel, row-major raster order
//   in_valid   - pixel_in valid
//   in_ready   - block accepts pixel_in this cycle
//   pixel_out  - binned pixel
//   out_valid  - pixel_out valid
//   out_ready  - downstream accepts pixel_out
//   out_eof    - last binned pixel of the frame, qualified by out_valid
module bin2x2_filter
  import bin2x2_filter_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = PIX_W,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_eof
);

  localparam int W        = PIXEL_BIT_WIDTH;
  localparam int XW       = cnt_w(IN_COLS);
  localparam int YW       = cnt_w(IN_ROWS);
  localparam int LB_DEPTH = IN_COLS / 2;
  localparam int AW       = cnt_w(LB_DEPTH);
  localparam int HW       = W + 1;
  localparam int SW       = W + 2;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [W-1:0]  held_q, held_d;
  logic [W-1:0]  pix_q, pix_d;
  logic          valid_q, valid_d;
  logic          eof_q, eof_d;

  logic          fire_in;
  logic          x_last, y_last;
  logic          out_load, lb_we;
  logic [AW-1:0] lb_addr;
  logic [HW-1:0] h_sum, lb_rd;
  logic [SW-1:0] s_sum;

  // A full output register only blocks input when it is not being drained.
  assign in_ready = !valid_q || out_ready;
  assign fire_in  = beat_fire(in_valid, in_ready);

  assign x_last = (x_q == XW'(IN_COLS - 1));
  assign y_last = (y_q == YW'(IN_ROWS - 1));

  assign h_sum   = {1'b0, held_q} + {1'b0, pixel_in};
  assign lb_addr = AW'(x_q >> 1);
  assign s_sum   = {1'b0, lb_rd} + {1'b0, h_sum};

  // Odd column closes a horizontal pair: even rows store it, odd rows emit.
  assign lb_we    = fire_in & x_q[0] & ~y_q[0];
  assign out_load = fire_in & x_q[0] & y_q[0];

  bin_line_buffer #(
    .DEPTH  (LB_DEPTH),
    .ADDR_W (AW),
    .DATA_W (HW)
  ) u_line_buffer (
    .clk       (clk),
    .wr_en_i   (lb_we),
    .wr_addr_i (lb_addr),
    .wr_data_i (h_sum),
    .rd_addr_i (lb_addr),
    .rd_data_o (lb_rd)
  );

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    held_d  = held_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    eof_d   = eof_q;

    if (fire_in) begin
      if (!x_q[0]) held_d = pixel_in;
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // Loading wins over draining so a same-cycle consume/load keeps valid high.
    if (out_load) begin
      valid_d = 1'b1;
      pix_d   = s_sum[SW-1:2];
      eof_d   = x_last && y_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
      eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      held_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      held_q  <= held_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
    end
  end

  assign pixel_out = pix_q;
  assign out_valid = valid_q;
  assign out_eof   = eof_q;

endmodule

// File: tb/tb_bin2x2_filter.sv
module tb_bin2x2_filter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pix;
    logic        eof;
  } exp_t;

  exp_t q4[$];
  exp_t q20[$];
  int   total = 0;
  int   bad   = 0;
  int   n20   = 0;

  logic [11:0] i4_pix = '0, o4_pix;
  logic        i4_valid = 1'b0, i4_ready, o4_valid, o4_ready = 1'b1, o4_eof;
  logic [11:0] i20_pix = '0, o20_pix;
  logic        i20_valid = 1'b0, i20_ready, o20_valid, o20_ready = 1'b1, o20_eof;

  logic [11:0] f4  [16];
  logic [11:0] f20 [400];

  bin2x2_filter #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(4), .IN_COLS(4)) u4 (
    .clk       (clk),
    .reset     (reset),
    .pixel_in  (i4_pix),
    .in_valid  (i4_valid),
    .in_ready  (i4_ready),
    .pixel_out (o4_pix),
    .out_valid (o4_valid),
    .out_ready (o4_ready),
    .out_eof   (o4_eof)
  );

  bin2x2_filter u20 (
    .clk       (clk),
    .reset     (reset),
    .pixel_in  (i20_pix),
    .in_valid  (i20_valid),
    .in_ready  (i20_ready),
    .pixel_out (o20_pix),
    .out_valid (o20_valid),
    .out_ready (o20_ready),
    .out_eof   (o20_eof)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && o4_valid && o4_ready) begin
      chk("u4_unexpected_output", (q4.size() != 0), 1);
      if (q4.size() != 0) begin
        e = q4.pop_front();
        chk("u4_pixel_out", o4_pix, e.pix);
        chk("u4_out_eof", o4_eof, e.eof);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && o20_valid && o20_ready) begin
      n20++;
      chk("u20_unexpected_output", (q20.size() != 0), 1);
      if (q20.size() != 0) begin
        e = q20.pop_front();
        chk("u20_pixel_out", o20_pix, e.pix);
        chk("u20_out_eof", o20_eof, e.eof);
      end
    end
  end

  task automatic model4();
    for (int by = 0; by < 2; by++) begin
      for (int bx = 0; bx < 2; bx++) begin
        int   s;
        exp_t e;
        s = int'(f4[(2*by)*4 + 2*bx]) + int'(f4[(2*by)*4 + 2*bx + 1])
          + int'(f4[(2*by+1)*4 + 2*bx]) + int'(f4[(2*by+1)*4 + 2*bx + 1]);
        e.pix = 12'(s / 4);
        e.eof = (by == 1) && (bx == 1);
        q4.push_back(e);
      end
    end
  endtask

  task automatic model20();
    for (int by = 0; by < 10; by++) begin
      for (int bx = 0; bx < 10; bx++) begin
        int   s;
        exp_t e;
        s = int'(f20[(2*by)*20 + 2*bx]) + int'(f20[(2*by)*20 + 2*bx + 1])
          + int'(f20[(2*by+1)*20 + 2*bx]) + int'(f20[(2*by+1)*20 + 2*bx + 1]);
        e.pix = 12'(s / 4);
        e.eof = (by == 9) && (bx == 9);
        q20.push_back(e);
      end
    end
  endtask

  task automatic send4(input logic [11:0] p);
    bit ok;
    ok = 1'b0;
    i4_pix   = p;
    i4_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (i4_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("u4_send_timeout", 0, 1);
  endtask

  task automatic send_frame4(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps && (i % 3 == 1)) begin
        i4_valid = 1'b0;
        i4_pix   = 12'h000;
        repeat (2) begin
          @(posedge clk);
          #1;
        end
      end
      send4(f4[i]);
    end
    i4_valid = 1'b0;
  endtask

  task automatic tick20();
    @(posedge clk);
    #1;
    o20_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send20(input logic [11:0] p);
    bit ok;
    if ($urandom_range(0, 3) == 0) begin
      i20_valid = 1'b0;
      i20_pix   = 12'($urandom);
      repeat ($urandom_range(1, 3)) tick20();
    end
    ok = 1'b0;
    i20_pix   = p;
    i20_valid = 1'b1;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if (i20_ready) ok = 1'b1;
      tick20();
    end
    if (!ok) chk("u20_send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 5000; k++) begin
      if (q4.size() == 0 && q20.size() == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    chk("drain_leftover", q4.size() + q20.size(), 0);
  endtask

  initial begin
    exp_t e;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", o4_valid, 0);
    chk("rst_out_eof", o4_eof, 0);
    chk("rst_pixel_out", o4_pix, 0);
    chk("rst_in_ready", i4_ready, 1);
    chk("rst_u20_out_valid", o20_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Ramp frame 0..15: expect 2, 4, 10, 12 with eof on the last
    for (int i = 0; i < 16; i++) f4[i] = 12'(i);
    model4();
    send_frame4(1'b0);
    drain();

    // Saturated frame with input gaps carrying junk pixels
    for (int i = 0; i < 16; i++) f4[i] = 12'hFFF;
    model4();
    send_frame4(1'b1);
    drain();

    // Floor behaviour: top-left block 1,1,1,0 bins to 0
    f4 = '{12'd1, 12'd1, 12'd7, 12'd8,
           12'd1, 12'd0, 12'd9, 12'd9,
           12'd3, 12'd3, 12'd3, 12'd3,
           12'd4, 12'd4, 12'd4, 12'd5};
    model4();
    send_frame4(1'b0);
    drain();

    // Backpressure: hold the first output for 5 cycles with input offered
    for (int i = 0; i < 16; i++) f4[i] = 12'(i * 3);
    model4();
    o4_ready = 1'b1;
    for (int i = 0; i < 5; i++) send4(f4[i]);
    o4_ready = 1'b0;
    send4(f4[5]);
    i4_pix   = f4[6];
    i4_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", i4_ready, 0);
      chk("stall_out_valid", o4_valid, 1);
      chk("stall_pixel_out", o4_pix, q4[0].pix);
    end
    @(posedge clk);
    #1;
    o4_ready = 1'b1;
    for (int i = 6; i < 16; i++) send4(f4[i]);
    i4_valid = 1'b0;
    drain();

    // Mid-frame reset after 6 beats, then a clean ramp frame
    e.pix = 12'd100;
    e.eof = 1'b0;
    q4.push_back(e);
    for (int i = 0; i < 6; i++) send4(12'd100);
    i4_valid = 1'b0;
    drain();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", o4_valid, 0);
    chk("midrst_out_eof", o4_eof, 0);
    chk("midrst_pixel_out", o4_pix, 0);
    chk("midrst_in_ready", i4_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) f4[i] = 12'(i);
    model4();
    send_frame4(1'b0);
    drain();

    // Two back-to-back 20x20 random frames with random gaps and backpressure
    for (int fr = 0; fr < 2; fr++) begin
      for (int i = 0; i < 400; i++) f20[i] = 12'($urandom_range(0, 4095));
      model20();
      for (int i = 0; i < 400; i++) send20(f20[i]);
    end
    i20_valid = 1'b0;
    o20_ready = 1'b1;
    drain();
    chk("u20_output_count", n20, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
